// File: rtl/rom_arbiter_pkg.sv
// ============================================================================
// rom_arbiter_pkg : shared ROM widths and enables, plus arbiter port ids
// Revision 1.0
// ============================================================================
`default_nettype none

package rom_arbiter_pkg;

   localparam int   InstAddrWidth = 32;
   localparam int   InstDataWidth = 32;
   localparam logic ChipEnable    = 1'b1;
   localparam logic RstEnable     = 1'b1;

   localparam logic ArbPortF      = 1'b0;
   localparam logic ArbPortD      = 1'b1;
   localparam int   ArbWaitWidth  = 4;

   // Saturating increment of the D-port starvation counter.
   function automatic logic [ArbWaitWidth-1:0] wait_inc(
      input logic [ArbWaitWidth-1:0] cnt,
      input logic [ArbWaitWidth-1:0] lim
   );
      return (cnt >= lim) ? lim : cnt + 1'b1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rom_arb_pick.sv
// ============================================================================
// rom_arb_pick : combinational grant decision between fetch (F) and D ports
// Build option: ROM_ARB_RR_EN selects round-robin instead of fixed priority.
// Revision 1.0
// ============================================================================
`default_nettype none

module rom_arb_pick
   import rom_arbiter_pkg::*;
#(
   parameter int MaxWait = 4
) (
   input  logic                    f_req,
   input  logic                    d_req,
   input  logic                    last,
   input  logic [ArbWaitWidth-1:0] wcnt,
   output logic                    gnt_f,
   output logic                    gnt_d
);

   logic d_wins;
   logic unused_cfg;

`ifdef ROM_ARB_RR_EN
   assign d_wins     = (last == ArbPortF);
   assign unused_cfg = ^{wcnt, (MaxWait == 0)};
`else
   assign d_wins     = (wcnt >= ArbWaitWidth'(MaxWait));
   assign unused_cfg = last;
`endif

   always_comb begin
      gnt_f = 1'b0;
      gnt_d = 1'b0;
      if (f_req && d_req) begin
         gnt_d = d_wins;
         gnt_f = !d_wins;
      end else begin
         gnt_f = f_req;
         gnt_d = d_req;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rom_arbiter.sv
// ============================================================================
// rom_arbiter : shares the instruction ROM read port between fetch and D port,
// returning the registered ROM word to the granted port one cycle later.
// Build option: ROM_ARB_RR_EN (round-robin; starvation counter removed).
// Revision 1.0
// ============================================================================
`default_nettype none

module rom_arbiter
   import rom_arbiter_pkg::*;
#(
   parameter int MaxWait = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     f_req,
   input  logic [InstAddrWidth-1:0] f_addr,
   output logic                     f_gnt,
   output logic                     f_rvalid,
   output logic [InstDataWidth-1:0] f_rdata,
   input  logic                     d_req,
   input  logic [InstAddrWidth-1:0] d_addr,
   output logic                     d_gnt,
   output logic                     d_rvalid,
   output logic [InstDataWidth-1:0] d_rdata,
   output logic                     rom_ce,
   output logic [InstAddrWidth-1:0] rom_addr,
   input  logic [InstDataWidth-1:0] rom_inst
);

   logic                     in_rst;
   logic                     pick_f, pick_d;
   logic [ArbWaitWidth-1:0]  wcnt;
   logic                     last_d, last_q;
   logic                     f_rvalid_d, f_rvalid_q;
   logic                     d_rvalid_d, d_rvalid_q;
   logic [InstDataWidth-1:0] f_rdata_d, f_rdata_q;
   logic [InstDataWidth-1:0] d_rdata_d, d_rdata_q;

   assign in_rst = (rst == RstEnable);

   rom_arb_pick #(
      .MaxWait (MaxWait)
   ) u_pick (
      .f_req (f_req),
      .d_req (d_req),
      .last  (last_q),
      .wcnt  (wcnt),
      .gnt_f (pick_f),
      .gnt_d (pick_d)
   );

   // Grants are masked while reset is held so nothing reaches the ROM.
   always_comb begin
      f_gnt      = pick_f && !in_rst;
      d_gnt      = pick_d && !in_rst;
      rom_ce     = (f_gnt || d_gnt) ? ChipEnable : ~ChipEnable;
      rom_addr   = f_gnt ? f_addr : (d_gnt ? d_addr : '0);
      f_rvalid_d = f_gnt;
      d_rvalid_d = d_gnt;
      f_rdata_d  = f_gnt ? rom_inst : f_rdata_q;
      d_rdata_d  = d_gnt ? rom_inst : d_rdata_q;
      last_d     = d_gnt ? ArbPortD : (f_gnt ? ArbPortF : last_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         last_q     <= ArbPortF;
         f_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         f_rdata_q  <= '0;
         d_rdata_q  <= '0;
      end else begin
         last_q     <= last_d;
         f_rvalid_q <= f_rvalid_d;
         d_rvalid_q <= d_rvalid_d;
         f_rdata_q  <= f_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

`ifdef ROM_ARB_RR_EN
   assign wcnt = '0;
`else
   logic [ArbWaitWidth-1:0] wcnt_d, wcnt_q;

   always_comb begin
      wcnt_d = '0;
      if (d_req && !d_gnt)
         wcnt_d = wait_inc(wcnt_q, ArbWaitWidth'(MaxWait));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable)
         wcnt_q <= '0;
      else
         wcnt_q <= wcnt_d;
   end

   assign wcnt = wcnt_q;
`endif

   assign f_rvalid = f_rvalid_q;
   assign d_rvalid = d_rvalid_q;
   assign f_rdata  = f_rdata_q;
   assign d_rdata  = d_rdata_q;

endmodule

`default_nettype wire
